// File: rtl/dl_rom_pkg.sv
// rtl/dl_rom_pkg.sv - shared types and constants for the download-loaded ROM bank
// Contents: download FSM state enum, legal bytes-per-word mask.
package dl_rom_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } dl_state_e;

  // Bit n set means NBYTES = n is a supported word width.
  localparam logic [7:0] NBYTES_LEGAL_MASK = 8'b0001_0110;

endpackage

// File: rtl/dl_rom_mem.sv
// rtl/dl_rom_mem.sv - single-clock simple dual-port RAM with registered read
// Ports: clk; we/waddr/wdata write port; raddr read address; rdata read data (1-cycle latency).
module dl_rom_mem #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Non-blocking read and write in the same block give read-before-write on an address collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dl_rom_bank.sv
// rtl/dl_rom_bank.sv - ROM bank filled by an ordered byte download stream
// Ports: I_CLK clock; I_RST sync active-high reset; I_ADDR/I_CE read address and active-low enable;
//        O_DATA read word (lane 0 in MSB); I_DLADDR/I_DLDATA/I_DLWR download byte stream;
//        O_READY region loaded; O_ERR sticky sequence error; O_CSUM 16-bit byte sum of the current load.
module dl_rom_bank
  import dl_rom_pkg::*;
#(
  parameter int          AW     = 12,
  parameter int          NBYTES = 4,
  parameter logic [16:0] BASE   = 17'h0A000,
  parameter logic [7:0]  FILL   = 8'h00
) (
  input  logic                I_CLK,
  input  logic                I_RST,
  input  logic [AW-1:0]       I_ADDR,
  input  logic                I_CE,
  output logic [8*NBYTES-1:0] O_DATA,
  input  logic [16:0]         I_DLADDR,
  input  logic [7:0]          I_DLDATA,
  input  logic                I_DLWR,
  output logic                O_READY,
  output logic                O_ERR,
  output logic [15:0]         O_CSUM
);

  localparam int DW    = 8 * NBYTES;
  localparam int LW    = (NBYTES > 1) ? $clog2(NBYTES) : 0;
  localparam int OW    = AW + LW;
  localparam int TOTAL = NBYTES * (2 ** AW);
  localparam logic [OW-1:0] LAST_OFF = OW'(TOTAL - 1);
  localparam logic [17:0]   LIMIT    = 18'(BASE) + 18'(TOTAL);
  localparam bit NB_OK = (NBYTES >= 1) && (NBYTES <= 4) && NBYTES_LEGAL_MASK[3'(NBYTES)];

  if (!NB_OK) begin : g_bad_nbytes
    $error("dl_rom_bank: NBYTES must be 1, 2 or 4");
  end

  dl_state_e       state_q, state_d;
  logic [OW-1:0]   exp_q, exp_d;
  logic [15:0]     csum_q, csum_d;
  logic            err_q, err_d;
  logic [7:0]      lane_buf_q [NBYTES];
  logic [7:0]      lane_buf_d [NBYTES];
  logic            ce_q, ce_d;
  logic            rdy_q, rdy_d;

  logic            in_range, strobe, accept;
  logic [OW-1:0]   off;
  int              lane_i;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_wdata, mem_rdata;

  // Offset is only meaningful when in range, where it always fits in OW bits.
  assign off      = OW'(I_DLADDR - BASE);
  assign in_range = ({1'b0, I_DLADDR} >= {1'b0, BASE}) && ({1'b0, I_DLADDR} < LIMIT);
  assign strobe   = I_DLWR && in_range;

  // Offset 0 starts (IDLE) or restarts (DONE) a load; in LOAD only the expected offset is taken.
  always_comb begin
    accept = 1'b0;
    if (strobe) begin
      unique case (state_q)
        S_IDLE, S_DONE: accept = (off == '0);
        S_LOAD:         accept = (off == exp_q);
        default:        accept = 1'b0;
      endcase
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = (off == LAST_OFF) ? S_DONE : S_LOAD;
    end
  end

  always_comb begin
    exp_d      = exp_q;
    csum_d     = csum_q;
    err_d      = err_q;
    lane_buf_d = lane_buf_q;
    lane_i     = int'(off) % NBYTES;
    mem_we     = 1'b0;
    mem_waddr  = AW'(off >> LW);
    mem_wdata  = '0;
    ce_d       = I_CE;
    rdy_d      = O_READY;

    // Assembled word: buffered lanes plus the byte arriving now in the last lane.
    for (int i = 0; i < NBYTES; i++) begin
      mem_wdata[8*(NBYTES-1-i) +: 8] = (i == NBYTES - 1) ? I_DLDATA : lane_buf_q[i];
    end

    if (accept) begin
      exp_d  = off + 1'b1;
      csum_d = (off == '0) ? {8'h00, I_DLDATA} : csum_q + {8'h00, I_DLDATA};
      for (int i = 0; i < NBYTES; i++) begin
        if (i == lane_i) begin
          lane_buf_d[i] = I_DLDATA;
        end
      end
      mem_we = (lane_i == NBYTES - 1);
      if (state_q == S_DONE) begin
        err_d = 1'b0;
      end
    end else if (strobe && (state_q != S_DONE)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      exp_q  <= '0;
      csum_q <= '0;
      err_q  <= 1'b0;
      ce_q   <= 1'b1;
      rdy_q  <= 1'b0;
      for (int i = 0; i < NBYTES; i++) begin
        lane_buf_q[i] <= 8'h00;
      end
    end else begin
      exp_q      <= exp_d;
      csum_q     <= csum_d;
      err_q      <= err_d;
      ce_q       <= ce_d;
      rdy_q      <= rdy_d;
      lane_buf_q <= lane_buf_d;
    end
  end

  dl_rom_mem #(
    .AW (AW),
    .DW (DW)
  ) u_mem (
    .clk   (I_CLK),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (I_ADDR),
    .rdata (mem_rdata)
  );

  assign O_READY = (state_q == S_DONE);
  assign O_ERR   = err_q;
  assign O_CSUM  = csum_q;
  // Enable and loaded status are captured with the address so the output tracks the read cycle.
  assign O_DATA  = ce_q ? '0 : (rdy_q ? mem_rdata : {NBYTES{FILL}});

endmodule

// File: doc/dl_rom_bank.md
DL_ROM_BANK -- requirements
Module: dl_rom_bank

Interface
REQ-001 SHALL have parameter AW, default 12: ROM word-address width; depth is 2**AW words.
REQ-002 SHALL have parameter NBYTES, default 4: bytes per ROM word, legal values 1, 2, 4.
REQ-003 SHALL have parameter BASE, default 17'h0A000: download byte address of ROM word 0, lane 0.
REQ-004 SHALL have parameter FILL, default 8'h00: byte replicated on O_DATA while not loaded.
REQ-005 SHALL have port I_CLK, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port I_RST, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port I_ADDR, input, AW: read word address.
REQ-008 SHALL have port I_CE, input, 1: active-low read chip enable.
REQ-009 SHALL have port O_DATA, output, 8*NBYTES: read data, with lane 0 in the most significant byte.
REQ-010 SHALL have port I_DLADDR, input, 17: download byte address.
REQ-011 SHALL have port I_DLDATA, input, 8: download byte.
REQ-012 SHALL have port I_DLWR, input, 1: download byte strobe, one byte per asserted cycle.
REQ-013 SHALL have port O_READY, output, 1: region fully loaded.
REQ-014 SHALL have port O_ERR, output, 1: sticky lane/sequence error.
REQ-015 SHALL have port O_CSUM, output, 16: modulo-2**16 sum of the bytes accepted since load start.

Function
REQ-016 SHALL decode a download byte as in range when BASE <= I_DLADDR < BASE + NBYTES*2**AW; offset = I_DLADDR - BASE, lane = offset mod NBYTES, word = offset / NBYTES.
REQ-017 SHALL ignore every out-of-range strobe: no state, checksum or error change.
REQ-018 SHALL implement FSM states IDLE, LOAD and DONE.
REQ-019 SHALL transition IDLE->LOAD on an in-range strobe at offset 0; in IDLE, in-range strobes at nonzero offsets SHALL set O_ERR and be discarded.
REQ-020 SHALL, in LOAD, accept a byte only if its offset equals the expected offset (starting at 0, incremented per accepted byte); a mismatch SHALL set O_ERR, discard the byte, and leave the expected offset unchanged.
REQ-021 SHALL place each accepted byte into a lane buffer, and SHALL write the assembled word to memory in the cycle the lane-(NBYTES-1) byte is accepted; with NBYTES=1 every byte is written directly.
REQ-022 SHALL add each accepted byte to O_CSUM with 16-bit wrap; O_CSUM is registered and updates 1 cycle after acceptance.
REQ-023 SHALL transition LOAD->DONE when the byte at the final offset (NBYTES*2**AW - 1) is accepted, and SHALL assert O_READY on the following cycle.
REQ-024 SHALL, in DONE, restart on an in-range strobe at offset 0: clear O_READY, clear O_ERR, load O_CSUM with that byte, enter LOAD, and accept the byte as offset 0; other in-range strobes in DONE SHALL be ignored.
REQ-025 SHALL give a read latency of exactly 1 cycle: O_DATA at cycle n+1 reflects I_ADDR and I_CE sampled at cycle n.
REQ-026 SHALL drive O_DATA to all zeros when the sampled I_CE = 1; when I_CE = 0 and O_READY = 0, O_DATA SHALL be FILL replicated in every byte; when I_CE = 0 and O_READY = 1, O_DATA SHALL be the memory word.
REQ-027 SHALL, on a same-cycle memory write and read of the same word, return the old word (read-before-write).
REQ-028 SHALL not lose or duplicate bytes when I_DLWR is asserted on consecutive cycles.

Reset
REQ-029 SHALL, while I_RST = 1 at a clock edge, set the state to IDLE, the expected offset to 0, the lane buffer to 0, O_READY = 0, O_ERR = 0, O_CSUM = 0, and O_DATA = 0.
REQ-030 SHALL not clear memory contents on reset; a reset during LOAD abandons the load, and the next load SHALL start at offset 0.

Structure
REQ-031 SHALL place the FSM state enum and the legal-NBYTES check constant in the shared package dl_rom_pkg.
REQ-032 SHALL use one sub-module, dl_rom_mem: a single-clock simple dual-port RAM of 2**AW x 8*NBYTES with a registered read.

Verification
REQ-033 SHALL cover the following case. Stimulus: AW=2, NBYTES=4; stream bytes 01..10 to offsets 0..15 back-to-back. Required response: O_READY=1 one cycle after the last byte, O_CSUM=16'h0088, and a read of word 1 with CE low gives 32'h05060708.
REQ-034 SHALL cover the following case. Stimulus: before load, read any address with CE low, FILL=8'hFF. Required response: O_DATA=32'hFFFFFFFF; with CE high, O_DATA=0.
REQ-035 SHALL cover the following case. Stimulus: during LOAD, skip offset 5 (send offset 6 after 4). Required response: O_ERR=1, the byte is discarded; resending offset 5 onward completes the load with O_READY=1 and O_ERR still 1.
REQ-036 SHALL cover the following case. Stimulus: strobes at BASE-1 and BASE+16. Required response: no change to the state, O_CSUM or O_ERR.
REQ-037 SHALL cover the following case. Stimulus: assert I_RST after 9 bytes, then fully reload with bytes of value 00. Required response: O_CSUM=0 and O_READY=1; words 0..3 read 0.
REQ-038 SHALL cover the following case. Stimulus: in DONE, write offset 0 with 8'h7F. Required response: O_READY=0 next cycle, O_CSUM=16'h007F, O_ERR cleared, state LOAD.
